pwm_multi: RTL and testbench

Multi-channel, parametrised PWM generator; successor to the single-channel `pwm` block in the LED controller. Drives `CHANNELS` LED outputs from one shared period counter. Adds:
- per-channel duty registers with glitch-free update at period boundaries;
- optional phase staggering between channels, to spread supply current;
- edge-aligned or center-aligned counting;
- a period-start strobe for upstream fade/sequencer logic.

---
 rtl/pwm_multi_pkg.sv | 14 +
 rtl/pwm_multi_if.sv | 8 +
 rtl/pwm_multi_channel.sv | 65 ++++++
 rtl/pwm_multi.sv | 84 ++++++++
 tb/tb_pwm_multi.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_multi_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
// Imported by the top, the per-channel slice and the testbench.
package pwm_pkg;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;

  typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

  // Phase offset of channel idx when channels are spread evenly over one period.
  function automatic int stagger_offset(int width, int channels, int idx);
    return idx * ((1 << width) / channels);
  endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// Global control bundle (synchronous reset and sleep) shared by LED-controller blocks.
interface global_if;
  logic reset;
  logic sleep;

  modport master (output reset, output sleep);
  modport slave  (input reset, input sleep);
endinterface

// File: rtl/pwm_multi_channel.sv
// One PWM output: shadow/active duty pair, phase adder, boundary detect and
// registered compare against the shared period counter.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int        WIDTH  = 8,
  parameter int        OFFSET = 0,
  parameter pwm_mode_e MODE   = PWM_EDGE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sleep,
  input  logic [WIDTH-1:0] cnt,
  input  pwm_dir_e         dir,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_duty,
  output logic             out
);

  localparam logic [WIDTH-1:0] OFF = WIDTH'(OFFSET);
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] pc;
  logic             boundary;
  logic             hit;

  // On the way down the compare is shifted by one so that the top and bottom
  // halves each contribute exactly d high cycles (2*d per center period).
  always_comb begin
    pc       = cnt + OFF;
    boundary = 1'b0;
    hit      = 1'b0;
    if (MODE == PWM_EDGE) begin
      boundary = (pc == MAX);
      hit      = (pc < active);
    end else begin
      boundary = (dir == DIR_DOWN) && (cnt == ONE);
      hit      = (dir == DIR_UP) ? (pc < active) : (pc <= active);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
      out    <= 1'b0;
    end else begin
      if (wr) begin
        shadow <= wr_duty;
      end
      if (sleep) begin
        out <= 1'b0;
      end else begin
        out <= hit;
        if (boundary) begin
          active <= shadow;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared edge- or center-aligned counter,
// per-channel duty slices and a period-start strobe for fade/sequencer logic.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int        WIDTH    = 8,
  parameter int        CHANNELS = 4,
  parameter pwm_mode_e MODE     = PWM_EDGE,
  parameter int        STAGGER  = 1,
  localparam int       CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  global_if.slave             glb,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]    cnt;
  pwm_dir_e            dir;
  logic [CHANNELS-1:0] wr_sel;

  // Direction flips as the endpoint is reached, so the MAX cycle counts as
  // "down" and the 0 cycle as "up": both halves are exactly MAX cycles long.
  always_ff @(posedge clk) begin
    if (glb.reset) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (!glb.sleep) begin
      if (MODE == PWM_EDGE) begin
        cnt <= cnt + 1'b1;
        dir <= DIR_UP;
      end else if (dir == DIR_UP) begin
        cnt <= cnt + 1'b1;
        if (cnt == MAX - 1'b1) begin
          dir <= DIR_DOWN;
        end
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == ONE) begin
          dir <= DIR_UP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (glb.reset) begin
      period_start <= 1'b0;
    end else begin
      period_start <= !glb.sleep && (cnt == '0);
    end
  end

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_sel[i] = wr_en && (int'(wr_ch) == i);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH  (WIDTH),
      .OFFSET ((MODE == PWM_EDGE && STAGGER != 0) ? stagger_offset(WIDTH, CHANNELS, i) : 0),
      .MODE   (MODE)
    ) u_ch (
      .clk     (clk),
      .reset   (glb.reset),
      .sleep   (glb.sleep),
      .cnt     (cnt),
      .dir     (dir),
      .wr      (wr_sel[i]),
      .wr_duty (wr_duty),
      .out     (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: staggered edge, plain edge and center variants share one
// stimulus stream and are checked every cycle against a period-arithmetic model.
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int W     = 8;
  localparam int CH    = 4;
  localparam int PER_E = 256;
  localparam int PER_C = 510;
  localparam int NDUT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  global_if glb_if ();

  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [W-1:0]  wr_duty;
  logic [CH-1:0] pwm_stag, pwm_flat, pwm_cent;
  logic          ps_stag, ps_flat, ps_cent;

  int err_count   = 0;
  int check_count = 0;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .MODE(PWM_EDGE), .STAGGER(1)) dut_stag (
    .clk(clk), .glb(glb_if), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .pwm_out(pwm_stag), .period_start(ps_stag));

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .MODE(PWM_EDGE), .STAGGER(0)) dut_flat (
    .clk(clk), .glb(glb_if), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .pwm_out(pwm_flat), .period_start(ps_flat));

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .MODE(PWM_CENTER), .STAGGER(1)) dut_cent (
    .clk(clk), .glb(glb_if), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .pwm_out(pwm_cent), .period_start(ps_cent));

  // Reference model: n is the position inside the current period of each variant.
  int            n_m  [NDUT];
  int            sh_m [NDUT][CH];
  int            ac_m [NDUT][CH];
  logic [CH-1:0] exp_out [NDUT];
  logic          exp_ps  [NDUT];
  bit            model_valid = 1'b0;

  function automatic bit is_center(int k);
    return k == 2;
  endfunction

  function automatic int period_of(int k);
    return is_center(k) ? PER_C : PER_E;
  endfunction

  function automatic int phase_of(int k, int i, int n);
    if (is_center(k)) return n;
    return (n + ((k == 0) ? i * PER_E / CH : 0)) % PER_E;
  endfunction

  // Center pulse is a window of d cycles either side of the period start.
  function automatic bit high_of(int k, int ph, int d);
    if (is_center(k)) return (ph < d) || (ph >= PER_C - d);
    return ph < d;
  endfunction

  function automatic logic [CH-1:0] dut_out(int k);
    case (k)
      0:       return pwm_stag;
      1:       return pwm_flat;
      default: return pwm_cent;
    endcase
  endfunction

  function automatic logic dut_ps(int k);
    case (k)
      0:       return ps_stag;
      1:       return ps_flat;
      default: return ps_cent;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic modelStep();
    int ph;
    for (int k = 0; k < NDUT; k++) begin
      if (glb_if.reset) begin
        n_m[k]     = 0;
        exp_out[k] = '0;
        exp_ps[k]  = 1'b0;
        for (int i = 0; i < CH; i++) begin
          sh_m[k][i] = 0;
          ac_m[k][i] = 0;
        end
      end else if (glb_if.sleep) begin
        exp_out[k] = '0;
        exp_ps[k]  = 1'b0;
        if (wr_en) sh_m[k][int'(wr_ch)] = int'(wr_duty);
      end else begin
        exp_ps[k] = (phase_of(k, 0, n_m[k]) == 0);
        for (int i = 0; i < CH; i++) begin
          ph = phase_of(k, i, n_m[k]);
          exp_out[k][i] = high_of(k, ph, ac_m[k][i]);
          if (ph == period_of(k) - 1) ac_m[k][i] = sh_m[k][i];
        end
        if (wr_en) sh_m[k][int'(wr_ch)] = int'(wr_duty);
        n_m[k] = (n_m[k] + 1) % period_of(k);
      end
    end
    if (glb_if.reset) model_valid = 1'b1;
  endtask

  // One clock: advance the model on the current inputs, then compare at the falling edge.
  task automatic tick();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    if (model_valid) begin
      for (int k = 0; k < NDUT; k++) begin
        checkOutput($sformatf("out_dut%0d", k), 32'(dut_out(k)), 32'(exp_out[k]));
        checkOutput($sformatf("ps_dut%0d", k), 32'(dut_ps(k)), 32'(exp_ps[k]));
      end
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] ch, input logic [W-1:0] duty);
    wr_en   = we;
    wr_ch   = ch;
    wr_duty = duty;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic waitPs(input int k, input int limit);
    int t = 0;
    wr_en = 1'b0;
    while (!dut_ps(k) && t < limit) begin
      tick();
      t++;
    end
    checkOutput($sformatf("ps_wait%0d", k), 32'(dut_ps(k)), 32'd1);
  endtask

  task automatic waitTwoPs(input int k, input int limit);
    waitPs(k, limit);
    tick();
    waitPs(k, limit);
  endtask

  // From a period_start cycle, count high cycles of one channel up to the next period_start.
  task automatic measurePeriod(input int k, input int ch, input int wr_at, input logic [W-1:0] wr_val,
                               input int limit, output int hi, output int len);
    hi  = 0;
    len = 0;
    do begin
      hi += int'(dut_out(k)[ch]);
      wr_en   = (len == wr_at);
      wr_ch   = 2'(ch);
      wr_duty = wr_val;
      tick();
      len++;
    end while (!dut_ps(k) && len < limit);
    wr_en = 1'b0;
  endtask

  initial begin
    logic [W-1:0]  sweep [4];
    logic [CH-1:0] prev;
    int            rise [CH];
    int            hi, len, any_high, sleep_left;

    sweep = '{8'h00, 8'h40, 8'h80, 8'hFF};
    glb_if.reset = 1'b1;
    glb_if.sleep = 1'b0;
    wr_en = 1'b0;
    wr_ch = '0;
    wr_duty = '0;
    repeat (3) tick();
    checkOutput("rst_out", {20'd0, pwm_cent, pwm_flat, pwm_stag}, 32'd0);
    checkOutput("rst_ps", {29'd0, ps_cent, ps_flat, ps_stag}, 32'd0);
    glb_if.reset = 1'b0;

    // Edge duty sweep on channel 0 of the unstaggered variant
    foreach (sweep[s]) begin
      applyStimulus(1'b1, 2'd0, sweep[s]);
      waitTwoPs(1, 600);
      measurePeriod(1, 0, -1, 8'h00, 600, hi, len);
      checkOutput($sformatf("sweep_hi_%0h", sweep[s]), 32'(hi), 32'(sweep[s]));
      checkOutput("sweep_len", 32'(len), 32'd256);
    end

    // Mid-period duty change must not disturb the running period
    applyStimulus(1'b1, 2'd1, 8'h20);
    waitTwoPs(1, 600);
    measurePeriod(1, 1, 15, 8'hC0, 600, hi, len);
    checkOutput("glitch_cur_hi", 32'(hi), 32'd32);
    measurePeriod(1, 1, -1, 8'h00, 600, hi, len);
    checkOutput("glitch_next_hi", 32'(hi), 32'd192);
    checkOutput("glitch_len", 32'(len), 32'd256);

    // Stagger: rising edges 64 cycles apart
    for (int i = 0; i < CH; i++) applyStimulus(1'b1, 2'(i), 8'h40);
    waitTwoPs(0, 600);
    prev = pwm_stag;
    for (int i = 0; i < CH; i++) rise[i] = -1;
    for (int t = 1; t <= 256; t++) begin
      tick();
      for (int i = 0; i < CH; i++)
        if (pwm_stag[i] && !prev[i] && rise[i] < 0) rise[i] = t;
      prev = pwm_stag;
    end
    for (int i = 0; i < CH; i++)
      checkOutput($sformatf("stag_rise%0d", i), 32'(rise[i]), 32'(64 * (CH - i)));
    checkOutput("stag_ps", 32'(ps_stag), 32'd1);

    // Center mode: 128-wide pulse around the bottom, change only at the bottom
    applyStimulus(1'b1, 2'd0, 8'h40);
    waitTwoPs(2, 1100);
    checkOutput("cent_high_at_ps", 32'(pwm_cent[0]), 32'd1);
    measurePeriod(2, 0, 100, 8'h10, 1100, hi, len);
    checkOutput("cent_hi", 32'(hi), 32'd128);
    checkOutput("cent_len", 32'(len), 32'd510);
    measurePeriod(2, 0, -1, 8'h00, 1100, hi, len);
    checkOutput("cent_new_hi", 32'(hi), 32'd32);

    // Sleep mid-period while rewriting channel 2
    repeat (100) tick();
    glb_if.sleep = 1'b1;
    any_high = 0;
    for (int t = 0; t < 100; t++) begin
      if (t == 50) applyStimulus(1'b1, 2'd2, 8'hA0);
      else tick();
      any_high += int'(|{pwm_cent, pwm_flat, pwm_stag, ps_cent, ps_flat, ps_stag});
    end
    checkOutput("sleep_quiet", 32'(any_high), 32'd0);
    glb_if.sleep = 1'b0;
    repeat (600) tick();

    // Reset mid-period with duty 0x80 loaded
    applyStimulus(1'b1, 2'd0, 8'h80);
    waitTwoPs(1, 600);
    repeat (60) tick();
    checkOutput("pre_rst_high", 32'(pwm_flat[0]), 32'd1);
    glb_if.reset = 1'b1;
    tick();
    glb_if.reset = 1'b0;
    checkOutput("mid_rst_out", {20'd0, pwm_cent, pwm_flat, pwm_stag}, 32'd0);
    checkOutput("mid_rst_ps", {29'd0, ps_cent, ps_flat, ps_stag}, 32'd0);
    tick();
    checkOutput("post_rst_ps", {29'd0, ps_cent, ps_flat, ps_stag}, 32'b111);
    any_high = 0;
    for (int t = 0; t < 600; t++) begin
      tick();
      any_high += int'(|{pwm_cent, pwm_flat, pwm_stag});
    end
    checkOutput("post_rst_low", 32'(any_high), 32'd0);

    // Randomized traffic: writes, sleep bursts and occasional resets
    sleep_left = 0;
    for (int t = 0; t < 3000; t++) begin
      glb_if.reset = ($urandom_range(0, 1499) == 0);
      if (sleep_left == 0 && $urandom_range(0, 299) == 0) sleep_left = $urandom_range(1, 60);
      glb_if.sleep = (sleep_left != 0);
      if (sleep_left != 0) sleep_left--;
      wr_en = ($urandom_range(0, 7) == 0);
      wr_ch = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       wr_duty = 8'h00;
        1:       wr_duty = 8'hFF;
        default: wr_duty = 8'($urandom);
      endcase
      tick();
    end
    glb_if.reset = 1'b0;
    glb_if.sleep = 1'b0;
    wr_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
